// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, types and sizing helpers for the 7-segment scanner.
package seg7_pkg;
    localparam logic DEF_ANODE_ACT_LO = 1'b1;
    localparam int   MAX_DIGITS       = 8;
    typedef logic [3:0] nibble_t;
    function automatic int cnt_w(input int prescale);
        return $clog2(prescale);
    endfunction
endpackage

// File: rtl/seg7_tick_div.sv
// seg7_tick_div: slot prescaler counting 0..PRESCALE-1 with a last-cycle tick.
module seg7_tick_div
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int CW       = cnt_w(PRESCALE)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [CW-1:0] ov_count,
    output logic          o_tick
);
    assign o_tick = ov_count == CW'(PRESCALE - 1);

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) ov_count <= '0;
        else       ov_count <= o_tick ? '0 : ov_count + 1'b1;
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed common-anode 7-segment scanner with tear-free loads and leading-zero blanking.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int   DIGITS       = 4,
    parameter int   PRESCALE     = 50000,
    parameter int   BLANK_CYCLES = 500,
    parameter logic ANODE_ACT_LO = DEF_ANODE_ACT_LO
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [4*DIGITS-1:0] iv_value,
    input  logic                i_load,
    input  logic                i_lz_en,
    output logic [3:0]          ov_nibble,
    output logic [DIGITS-1:0]   ov_anode,
    output logic                o_frame
);
    localparam int CW = cnt_w(PRESCALE);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [CW-1:0]              count, count_d1;
    logic [IW-1:0]              idx, idx_d1;
    logic                       tick, boundary, lz_q, supp_d1, zero_run;
    nibble_t [DIGITS-1:0]       shadow, display;
    logic [DIGITS-1:0]          lead_zero, supp, anode_on;

    seg7_tick_div #(.PRESCALE(PRESCALE), .CW(CW)) u_div (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .ov_count (count),
        .o_tick   (tick)
    );

    assign boundary = tick && idx == IW'(DIGITS - 1);

    // count_d1/idx_d1/supp_d1 describe the slot currently on ov_nibble; the anode is built from them one cycle later
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && display[k] == 4'h0;
            lead_zero[k] = zero_run;
        end
        supp     = lead_zero & {DIGITS{lz_q}} & ~DIGITS'(1);
        anode_on = (count_d1 >= CW'(BLANK_CYCLES) && !supp_d1) ? DIGITS'(1) << idx_d1 : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            idx       <= '0;
            idx_d1    <= '0;
            count_d1  <= '0;
            lz_q      <= 1'b0;
            supp_d1   <= 1'b0;
            shadow    <= '0;
            display   <= '0;
            o_frame   <= 1'b0;
            ov_nibble <= '0;
            ov_anode  <= {DIGITS{ANODE_ACT_LO}};
        end else begin
            if (tick) idx <= boundary ? '0 : idx + 1'b1;
            if (tick) lz_q <= i_lz_en;
            if (i_load) shadow <= iv_value;
            if (boundary) display <= i_load ? iv_value : shadow;
            o_frame   <= boundary;
            ov_nibble <= display[idx];
            idx_d1    <= idx;
            count_d1  <= count;
            supp_d1   <= supp[idx];
            ov_anode  <= ANODE_ACT_LO ? ~anode_on : anode_on;
        end
endmodule
